inst_rr_scheduler: RTL and testbench

//  Round-robin scheduler that shares one resource slot among the NUM_REQ child instances
//  of a root module (default 5, one per inst_0..inst_4).

---
 rtl/sched_pkg.sv | 19 +
 rtl/rr_pick.sv | 30 +++
 rtl/inst_rr_scheduler.sv | 115 +++++++++++
 tb/tb_inst_rr_scheduler.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared types and defaults for the round-robin instance scheduler.
// SCHED_TIMEOUT_EN (optional macro) enables the forced-release hold counter in the top.
package sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT   = 2'd1,
    S_RELEASE = 2'd2
  } sched_state_t;

  localparam int DEF_NUM_REQ  = 5;
  localparam int DEF_MAX_HOLD = 16;

  // Increment an index modulo n; the last index wraps back to 0.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: returns the first set request scanning from ptr upward,
// wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 5,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  int w_pos;

  // Scan from the farthest position down to ptr so the closest set request wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    w_pos = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_pos = int'(ptr) + k;
      if (w_pos >= NUM_REQ) w_pos = w_pos - NUM_REQ;
      if (req[w_pos]) begin
        valid = 1'b1;
        idx   = IDX_W'(w_pos);
      end
    end
  end

endmodule

// File: rtl/inst_rr_scheduler.sv
// Round-robin scheduler sharing one resource slot among NUM_REQ child instances.
// Define SCHED_TIMEOUT_EN to force release after MAX_HOLD grant cycles without done.
module inst_rr_scheduler
  import sched_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy,
  output logic               timeout_pulse
);

  sched_state_t       r_state;
  sched_state_t       w_state_next;
  logic [NUM_REQ-1:0] r_grant;
  logic [IDX_W-1:0]   r_grant_idx;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   w_ptr_next;
  logic [IDX_W-1:0]   w_pick_idx;
  logic               w_pick_valid;
  logic               w_owner_done;
  logic               w_expire;

  rr_pick #(
    .NUM_REQ(NUM_REQ),
    .IDX_W  (IDX_W)
  ) u_pick (
    .req  (req),
    .ptr  (r_ptr),
    .valid(w_pick_valid),
    .idx  (w_pick_idx)
  );

  assign w_owner_done = done[r_grant_idx];
  assign w_ptr_next   = IDX_W'(wrap_inc(int'(r_grant_idx), NUM_REQ));

`ifdef SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(MAX_HOLD + 1);

  logic [CNT_W-1:0] r_hold_cnt;
  logic             r_forced;
  logic             w_forced;

  // Held at zero outside GRANT so every grant starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_cnt <= '0;
    end else if (r_state != S_GRANT) begin
      r_hold_cnt <= '0;
    end else if (r_hold_cnt != CNT_W'(MAX_HOLD)) begin
      r_hold_cnt <= r_hold_cnt + 1'b1;
    end
  end

  // Expiry fires on the MAX_HOLD-th grant cycle; done on that same cycle wins.
  assign w_expire = (r_state == S_GRANT) && (r_hold_cnt >= CNT_W'(MAX_HOLD - 1));
  assign w_forced = w_expire && !w_owner_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_forced <= 1'b0;
    else        r_forced <= w_forced;
  end
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_pick_valid) w_state_next = S_GRANT;
      S_GRANT:   if (w_owner_done || w_expire) w_state_next = S_RELEASE;
      S_RELEASE: w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Grant is loaded on arbitration and cleared on release, which also rotates ptr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant     <= '0;
      r_grant_idx <= '0;
      r_ptr       <= '0;
    end else if (r_state == S_IDLE && w_pick_valid) begin
      r_grant     <= NUM_REQ'(1) << w_pick_idx;
      r_grant_idx <= w_pick_idx;
    end else if (r_state == S_GRANT && w_state_next == S_RELEASE) begin
      r_grant <= '0;
      r_ptr   <= w_ptr_next;
    end
  end

  always_comb begin
    grant     = r_grant;
    grant_idx = r_grant_idx;
    busy      = (r_state != S_IDLE);
`ifdef SCHED_TIMEOUT_EN
    timeout_pulse = r_forced && (r_state == S_RELEASE);
`else
    timeout_pulse = 1'b0;
`endif
  end

endmodule

// File: tb/tb_inst_rr_scheduler.sv
// Self-checking bench for inst_rr_scheduler: cycle table plus scoreboard of grant order.
// Covers both builds; the forced-release checks follow SCHED_TIMEOUT_EN.
module tb_inst_rr_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] req;
  logic [4:0] done;
  logic [4:0] grant;
  logic [2:0] grant_idx;
  logic       busy;
  logic       timeout_pulse;

  int totalCnt = 0;
  int badCnt   = 0;
  int sbQ[$];
  logic [4:0] prevGrant = '0;

  typedef struct {
    logic [4:0] req;
    logic [4:0] done;
    logic [4:0] expGrant;
    int         expIdx;
    logic       expBusy;
    logic       expTp;
    int         pushIdx;
  } vec_t;

  vec_t vecs[13];

  inst_rr_scheduler #(
    .NUM_REQ (5),
    .MAX_HOLD(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .done         (done),
    .grant        (grant),
    .grant_idx    (grant_idx),
    .busy         (busy),
    .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    totalCnt++;
    if (act != exp) begin
      badCnt++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] r, input logic [4:0] d);
    req  = r;
    done = d;
  endtask

  // Advance one edge, sample 1ns later, and score any new grant against the queue.
  task automatic tick();
    int e;
    @(posedge clk);
    #1;
    if (grant != 5'b0 && prevGrant == 5'b0) begin
      if (sbQ.size() == 0) begin
        checkOutput("sb_unexpected_grant", int'(grant), 0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("sb_grant", int'(grant), 1 << e);
        checkOutput("sb_idx", int'(grant_idx), e);
      end
    end
    prevGrant = grant;
  endtask

  task automatic serve(input logic [4:0] r, input int e);
    sbQ.push_back(e);
    applyStimulus(r, 5'b0);
    for (int c = 0; c < 10; c++) begin
      tick();
      if (grant != 5'b0) break;
    end
    checkOutput("serve_grant", int'(grant), 1 << e);
    checkOutput("serve_idx", int'(grant_idx), e);
    applyStimulus(5'b0, 5'(1 << e));
    tick();
    checkOutput("serve_rel_grant", int'(grant), 0);
    checkOutput("serve_rel_busy", int'(busy), 1);
    applyStimulus(5'b0, 5'b0);
    tick();
    checkOutput("serve_idle_busy", int'(busy), 0);
  endtask

  initial begin
    int rises;
    int held;
    int zeroRun;
    int errRun;

    //          req       done      expGrant  idx busy tp push
    vecs[0]  = '{5'b00100, 5'b00000, 5'b00100, 2, 1'b1, 1'b0, 2};
    vecs[1]  = '{5'b00100, 5'b00000, 5'b00100, 2, 1'b1, 1'b0, -1};
    vecs[2]  = '{5'b00000, 5'b00000, 5'b00100, 2, 1'b1, 1'b0, -1};
    vecs[3]  = '{5'b00000, 5'b00000, 5'b00100, 2, 1'b1, 1'b0, -1};
    vecs[4]  = '{5'b00000, 5'b00100, 5'b00000, 2, 1'b1, 1'b0, -1};
    vecs[5]  = '{5'b00000, 5'b00000, 5'b00000, 2, 1'b0, 1'b0, -1};
    vecs[6]  = '{5'b00000, 5'b11111, 5'b00000, 2, 1'b0, 1'b0, -1};
    vecs[7]  = '{5'b00010, 5'b00000, 5'b00010, 1, 1'b1, 1'b0, 1};
    vecs[8]  = '{5'b00000, 5'b00100, 5'b00010, 1, 1'b1, 1'b0, -1};
    vecs[9]  = '{5'b00000, 5'b11101, 5'b00010, 1, 1'b1, 1'b0, -1};
    vecs[10] = '{5'b00000, 5'b00010, 5'b00000, 1, 1'b1, 1'b0, -1};
    vecs[11] = '{5'b00000, 5'b00000, 5'b00000, 1, 1'b0, 1'b0, -1};
    vecs[12] = '{5'b11111, 5'b00000, 5'b00100, 2, 1'b1, 1'b0, 2};

    // Reset held with every request raised: outputs must stay quiet.
    rst_n = 1'b0;
    applyStimulus(5'b11111, 5'b0);
    for (int c = 0; c < 3; c++) begin
      tick();
      checkOutput("rst_grant", int'(grant), 0);
      checkOutput("rst_busy", int'(busy), 0);
      checkOutput("rst_idx", int'(grant_idx), 0);
      checkOutput("rst_tp", int'(timeout_pulse), 0);
    end
    applyStimulus(5'b0, 5'b0);
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].req, vecs[i].done);
      if (vecs[i].pushIdx >= 0) sbQ.push_back(vecs[i].pushIdx);
      tick();
      checkOutput($sformatf("vec%0d_grant", i), int'(grant), int'(vecs[i].expGrant));
      checkOutput($sformatf("vec%0d_idx", i), int'(grant_idx), vecs[i].expIdx);
      checkOutput($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].expBusy));
      checkOutput($sformatf("vec%0d_tp", i), int'(timeout_pulse), int'(vecs[i].expTp));
    end

    // Asynchronous reset in the middle of a grant.
    applyStimulus(5'b0, 5'b0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_grant", int'(grant), 0);
    checkOutput("async_rst_busy", int'(busy), 0);
    checkOutput("async_rst_idx", int'(grant_idx), 0);
    tick();
    rst_n = 1'b1;

    // Full rotation from ptr 0 with each owner finishing on its second grant cycle.
    foreach (vecs[i]) if (i < 0) sbQ.push_back(0);
    sbQ.push_back(0); sbQ.push_back(1); sbQ.push_back(2);
    sbQ.push_back(3); sbQ.push_back(4); sbQ.push_back(0);
    applyStimulus(5'b11111, 5'b0);
    rises = 0;
    held = 0;
    zeroRun = 0;
    for (int c = 0; c < 200 && rises < 6; c++) begin
      tick();
      if (grant != 5'b0) begin
        if (held == 0) begin
          rises++;
          if (rises > 1) checkOutput("rot_gap", zeroRun, 2);
        end
        held++;
        zeroRun = 0;
        done = (held == 2) ? grant : 5'b0;
      end else begin
        held = 0;
        zeroRun++;
        done = 5'b0;
      end
    end
    checkOutput("rot_count", rises, 6);
    applyStimulus(5'b0, 5'b00001);
    tick();
    checkOutput("rot_end_grant", int'(grant), 0);
    applyStimulus(5'b0, 5'b0);
    tick();

    // Pointer wrap: owner 4, then 0 beats 3, then 3.
    serve(5'b10000, 4);
    serve(5'b01001, 0);
    serve(5'b01001, 3);

    // Owner 3 never signals done.
    sbQ.push_back(3);
    applyStimulus(5'b01000, 5'b0);
    for (int c = 0; c < 10; c++) begin
      tick();
      if (grant != 5'b0) break;
    end
    checkOutput("hold_grant", int'(grant), 5'b01000);
    applyStimulus(5'b0, 5'b0);
`ifdef SCHED_TIMEOUT_EN
    held = 1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (grant == 5'b0) break;
      held++;
    end
    checkOutput("to_hold_cycles", held, 4);
    checkOutput("to_pulse", int'(timeout_pulse), 1);
    checkOutput("to_busy", int'(busy), 1);
    tick();
    checkOutput("to_pulse_end", int'(timeout_pulse), 0);
    checkOutput("to_idle_busy", int'(busy), 0);
`else
    errRun = 0;
    for (int c = 0; c < 120; c++) begin
      tick();
      if (grant != 5'b01000 || timeout_pulse != 1'b0) errRun++;
    end
    checkOutput("hold_long", errRun, 0);
    applyStimulus(5'b0, 5'b01000);
    tick();
    checkOutput("hold_rel_grant", int'(grant), 0);
    applyStimulus(5'b0, 5'b0);
    tick();
`endif
    serve(5'b11111, 4);

    checkOutput("sb_left", sbQ.size(), 0);
    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
